// File: rtl/reg_list_seq.sv
// reg_list_seq
//   Register-list walker for block transfers (LDM/STM-style). On start it
//   latches a register list and direction, then issues every set bit's
//   register index, one per accepted beat, through a valid/ready handshake.
//   Lists of any population are covered, including the empty list.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; list, direction and popcount latched on start
//   RUN   | beat presented on reg_idx/beat_num/last, advances on handshake
//   FIN   | one-cycle done pulse, busy still high, then back to IDLE
//
// Ports
//   clk        in   clock, all logic on rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a new walk (sampled only in IDLE)
//   reg_list   in   register list, sampled with start
//   desc       in   0: lowest index first, 1: highest index first
//   busy       out  from the cycle after an accepted start through done
//   idx_valid  out  current beat valid
//   idx_ready  in   consumer accepts beat when idx_valid & idx_ready
//   reg_idx    out  register index of current beat
//   beat_num   out  0-based ordinal of current beat
//   last       out  current beat is the final one
//   total_cnt  out  popcount of the latched list
//   done       out  one-cycle pulse at walk completion
module reg_list_seq #(
    parameter int LIST_W = 16,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LIST_W-1:0] reg_list,
    input  logic              desc,
    output logic              busy,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [CNT_W-1:0]  beat_num,
    output logic              last,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state;
    logic [LIST_W-1:0] mask;
    logic              dir;

    // Priority select: lowest set bit when d=0, highest set bit when d=1.
    // The loop order lets the last matching assignment win.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [LIST_W-1:0] m,
                                                  input logic d);
        logic [IDX_W-1:0] r;
        r = '0;
        if (d) begin
            for (int i = 0; i < LIST_W; i++)
                if (m[i]) r = IDX_W'(i);
        end else begin
            for (int i = LIST_W - 1; i >= 0; i--)
                if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] pop_cnt(input logic [LIST_W-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LIST_W; i++)
            c = c + CNT_W'(m[i]);
        return c;
    endfunction

    function automatic logic single_bit(input logic [LIST_W-1:0] m);
        return (m != '0) && ((m & (m - LIST_W'(1))) == '0);
    endfunction

    logic              handshake;
    logic [LIST_W-1:0] mask_clr;
    logic [IDX_W-1:0]  next_idx;
    logic              next_last;
    logic [IDX_W-1:0]  first_idx;
    logic              first_last;
    logic [CNT_W-1:0]  list_cnt;

    assign handshake  = idx_valid & idx_ready;
    // reg_idx always names the beat being offered, so it is the bit to retire.
    assign mask_clr   = mask & ~(LIST_W'(1) << reg_idx);
    assign next_idx   = pick_idx(mask_clr, dir);
    assign next_last  = single_bit(mask_clr);
    assign first_idx  = pick_idx(reg_list, desc);
    assign first_last = single_bit(reg_list);
    assign list_cnt   = pop_cnt(reg_list);

    // Outputs are registered; the next beat's index/last are precomputed from
    // the mask with the current bit cleared so they appear right after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mask      <= '0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            idx_valid <= 1'b0;
            reg_idx   <= '0;
            beat_num  <= '0;
            last      <= 1'b0;
            total_cnt <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask      <= reg_list;
                        dir       <= desc;
                        total_cnt <= list_cnt;
                        beat_num  <= '0;
                        busy      <= 1'b1;
                        reg_idx   <= first_idx;
                        last      <= first_last;
                        if (reg_list != '0) begin
                            idx_valid <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            idx_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (handshake) begin
                        mask     <= mask_clr;
                        beat_num <= beat_num + CNT_W'(1);
                        if (last) begin
                            idx_valid <= 1'b0;
                            last      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_FIN;
                        end else begin
                            reg_idx <= next_idx;
                            last    <= next_last;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    idx_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_list_seq.sv
// tb_reg_list_seq
//   Directed bench for reg_list_seq: ascending/descending walks, full and
//   empty lists, stalls with a mid-walk start, and reset in the middle of a walk.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_reg_list_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] reg_list;
    logic        desc;
    logic        busy;
    logic        idx_valid;
    logic        idx_ready;
    logic [3:0]  reg_idx;
    logic [4:0]  beat_num;
    logic        last;
    logic [4:0]  total_cnt;
    logic        done;

    int total;
    int bad;
    int exp_idx [16];

    reg_list_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_list  (reg_list),
        .desc      (desc),
        .busy      (busy),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .reg_idx   (reg_idx),
        .beat_num  (beat_num),
        .last      (last),
        .total_cnt (total_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk_idle(tag);
        chk({tag, ".reg_idx"},   32'(reg_idx),   32'd0);
        chk({tag, ".beat_num"},  32'(beat_num),  32'd0);
        chk({tag, ".last"},      32'(last),      32'd0);
        chk({tag, ".total_cnt"}, 32'(total_cnt), 32'd0);
    endtask

    // Full walk with idx_ready held high; expected indices come from exp_idx[0..n-1].
    task automatic run_walk(input string tag, input logic [15:0] lst, input logic d, input int n);
        start     = 1'b1;
        reg_list  = lst;
        desc      = d;
        idx_ready = 1'b1;
        tick();
        start    = 1'b0;
        reg_list = 16'hA5A5;
        desc     = ~d;
        chk({tag, ".total_cnt"}, 32'(total_cnt), 32'(n));
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s.b%0d.busy", tag, k),  32'(busy),      32'd1);
            chk($sformatf("%s.b%0d.valid", tag, k), 32'(idx_valid), 32'd1);
            chk($sformatf("%s.b%0d.idx", tag, k),   32'(reg_idx),   32'(exp_idx[k]));
            chk($sformatf("%s.b%0d.beat", tag, k),  32'(beat_num),  32'(k));
            chk($sformatf("%s.b%0d.last", tag, k),  32'(last),      32'(k == n - 1));
            chk($sformatf("%s.b%0d.done", tag, k),  32'(done),      32'd0);
            tick();
        end
        chk({tag, ".fin.valid"}, 32'(idx_valid), 32'd0);
        chk({tag, ".fin.done"},  32'(done),      32'd1);
        chk({tag, ".fin.busy"},  32'(busy),      32'd1);
        tick();
        chk_idle({tag, ".after"});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        reg_list  = '0;
        desc      = 1'b0;
        idx_ready = 1'b0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");
        tick();
        chk_reset("reset.hold");

        // T1: ascending walk of 16'h8421
        exp_idx[0] = 0; exp_idx[1] = 5; exp_idx[2] = 10; exp_idx[3] = 15;
        run_walk("t1", 16'h8421, 1'b0, 4);

        // T2: descending walk of the same list
        exp_idx[0] = 15; exp_idx[1] = 10; exp_idx[2] = 5; exp_idx[3] = 0;
        run_walk("t2", 16'h8421, 1'b1, 4);

        // T3: full list, 16 back-to-back beats, done 17 cycles after start
        for (int i = 0; i < 16; i++) exp_idx[i] = i;
        run_walk("t3", 16'hFFFF, 1'b0, 16);

        // T4: empty list
        start    = 1'b1;
        reg_list = 16'h0000;
        tick();
        start = 1'b0;
        chk("t4.valid", 32'(idx_valid), 32'd0);
        chk("t4.done",  32'(done),      32'd1);
        chk("t4.busy",  32'(busy),      32'd1);
        chk("t4.total", 32'(total_cnt), 32'd0);
        tick();
        chk_idle("t4.after");

        // T5: stalls, ignored mid-walk start, then a second accepted start
        start     = 1'b1;
        reg_list  = 16'h0014;
        desc      = 1'b0;
        idx_ready = 1'b0;
        tick();
        chk("t5.c1.idx",  32'(reg_idx),  32'd2);
        chk("t5.c1.beat", 32'(beat_num), 32'd0);
        chk("t5.c1.last", 32'(last),     32'd0);
        start    = 1'b1;
        reg_list = 16'hFFFF;
        desc     = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.c2.valid", 32'(idx_valid), 32'd1);
        chk("t5.c2.idx",   32'(reg_idx),   32'd2);
        chk("t5.c2.beat",  32'(beat_num),  32'd0);
        chk("t5.c2.total", 32'(total_cnt), 32'd2);
        tick();
        chk("t5.c3.idx",  32'(reg_idx),  32'd2);
        chk("t5.c3.last", 32'(last),     32'd0);
        idx_ready = 1'b1;
        tick();
        idx_ready = 1'b0;
        chk("t5.c4.idx",  32'(reg_idx),  32'd4);
        chk("t5.c4.beat", 32'(beat_num), 32'd1);
        chk("t5.c4.last", 32'(last),     32'd1);
        tick();
        chk("t5.c5.valid", 32'(idx_valid), 32'd1);
        chk("t5.c5.idx",   32'(reg_idx),   32'd4);
        chk("t5.c5.beat",  32'(beat_num),  32'd1);
        chk("t5.c5.last",  32'(last),      32'd1);
        chk("t5.c5.done",  32'(done),      32'd0);
        idx_ready = 1'b1;
        tick();
        chk("t5.fin.valid", 32'(idx_valid), 32'd0);
        chk("t5.fin.done",  32'(done),      32'd1);
        tick();
        chk_idle("t5.after");
        exp_idx[0] = 4; exp_idx[1] = 2;
        run_walk("t5b", 16'h0014, 1'b1, 2);

        // T6: reset after the third handshake of 16'h00FF
        start     = 1'b1;
        reg_list  = 16'h00FF;
        desc      = 1'b0;
        idx_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6.b%0d.idx", k), 32'(reg_idx), 32'(k));
            tick();
        end
        chk("t6.b3.idx", 32'(reg_idx), 32'd3);
        rst      = 1'b1;
        start    = 1'b1;
        reg_list = 16'hFFFF;
        tick();
        chk_reset("t6.rst");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_reset("t6.post");
        tick();
        chk("t6.nodone", 32'(done), 32'd0);
        exp_idx[0] = 15; exp_idx[1] = 0;
        run_walk("t6b", 16'h8001, 1'b1, 2);

        // single-bit list at the top index
        exp_idx[0] = 15;
        run_walk("single", 16'h8000, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
